// File: rtl/toy_bus_mem_slave_pipe.sv
// Pipelined memory slave: request/ack handshake with credit-limited ack FIFO.
// Define TOY_BUS_MEM_SLAVE_WR_ACK_EN to make writes return an ack.
module toy_bus_mem_slave_pipe #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int SB_W      = 32,
    parameter int MEM_AW    = 24,
    parameter int RD_LAT    = 2,
    parameter int ACK_DEPTH = 4,
    parameter int NODE_ID   = 0,
    localparam int STRB_W   = DATA_W / 8,
    localparam int CW       = $clog2(ACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_opcode,
    input  logic [ID_W-1:0]   req_src_id,
    input  logic [ID_W-1:0]   req_tgt_id,
    input  logic [SB_W-1:0]   req_sideband,
    output logic              ack_vld,
    input  logic              ack_rdy,
    output logic              ack_opcode,
    output logic [DATA_W-1:0] ack_data,
    output logic [SB_W-1:0]   ack_sideband,
    output logic [ID_W-1:0]   ack_src_id,
    output logic [ID_W-1:0]   ack_tgt_id,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [STRB_W-1:0] mem_wr_byte_en,
    output logic [SB_W-1:0]   mem_req_sideband,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [SB_W-1:0]   mem_ack_sideband,
    output logic [CW-1:0]     credit_cnt
);

    localparam int OFS = $clog2(STRB_W);
    localparam int PW  = (ACK_DEPTH > 1) ? $clog2(ACK_DEPTH) : 1;

`ifdef TOY_BUS_MEM_SLAVE_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sb;
        logic [ID_W-1:0]   id;
        logic              op;
    } ack_ent_t;

    logic            accept;
    logic            ack_prod;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] push_id;
    logic            push_op;
    ack_ent_t        push_ent;
    ack_ent_t        head;

    logic [CW-1:0]   credit_q, credit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    ack_ent_t        fifo_q [ACK_DEPTH];

    logic            unused_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(ACK_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit is the only gate on acceptance; a pop frees it one cycle later.
    assign req_rdy  = (credit_q < CW'(ACK_DEPTH));
    assign accept   = req_vld && req_rdy;
    assign ack_prod = accept && (!req_opcode || WR_ACK);

    assign mem_en           = accept;
    assign mem_wr_en        = accept && req_opcode;
    assign mem_addr         = req_addr[OFS+MEM_AW-1:OFS];
    assign mem_wr_data      = req_data;
    assign mem_wr_byte_en   = req_strb;
    assign mem_req_sideband = req_sideband;

    // Stage 1 is the issue cycle; stage RD_LAT pushes at the capture edge.
    if (RD_LAT == 1) begin : g_lat1
        assign push    = ack_prod;
        assign push_id = req_src_id;
        assign push_op = req_opcode;
    end else begin : g_pipe
        localparam int NS = RD_LAT - 1;

        logic [NS-1:0]           vld_q;
        logic [NS-1:0]           op_q;
        logic [NS-1:0][ID_W-1:0] id_q;
        logic [NS:0]             vld_sh;
        logic [NS:0]             op_sh;
        logic [NS:0][ID_W-1:0]   id_sh;

        assign vld_sh = {vld_q, ack_prod};
        assign op_sh  = {op_q, req_opcode};
        assign id_sh  = {id_q, req_src_id};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                op_q  <= '0;
                id_q  <= '0;
            end else begin
                vld_q <= vld_sh[NS-1:0];
                op_q  <= op_sh[NS-1:0];
                id_q  <= id_sh[NS-1:0];
            end
        end

        assign push    = vld_q[NS-1];
        assign push_id = id_q[NS-1];
        assign push_op = op_q[NS-1];
    end

    always_comb begin
        push_ent      = '0;
        push_ent.data = push_op ? '0 : mem_rd_data;
        push_ent.sb   = mem_ack_sideband;
        push_ent.id   = push_id;
        push_ent.op   = push_op;
    end

    assign pop = ack_vld && ack_rdy;

    always_comb begin
        credit_d = credit_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (ack_prod && !pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!ack_prod && pop) begin
            credit_d = credit_q - CW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d = nxt(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = nxt(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
    end

    assign head         = fifo_q[rd_ptr_q];
    assign ack_vld      = (cnt_q != '0);
    assign ack_opcode   = ack_vld && head.op;
    assign ack_data     = ack_vld ? head.data : '0;
    assign ack_sideband = ack_vld ? head.sb : '0;
    assign ack_tgt_id   = ack_vld ? head.id : '0;
    assign ack_src_id   = ID_W'(NODE_ID);
    assign credit_cnt   = credit_q;

    assign unused_ok = ^{req_tgt_id, req_addr};

endmodule

// File: tb/tb_toy_bus_mem_slave_pipe.sv
// Bench for toy_bus_mem_slave_pipe: scoreboard plus directed sequences.
// Instance A uses defaults; instance B uses RD_LAT=1, ACK_DEPTH=3.
module tb_toy_bus_mem_slave_pipe;

`ifdef TOY_BUS_MEM_SLAVE_WR_ACK_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         req_vld_a, req_rdy_a, req_op_a;
    logic [31:0]  req_addr_a, req_strb_a, req_sb_a;
    logic [255:0] req_data_a;
    logic [3:0]   req_src_a, req_tgt_a;
    logic         ack_vld_a, ack_rdy_a, ack_op_a;
    logic [255:0] ack_data_a;
    logic [31:0]  ack_sb_a;
    logic [3:0]   ack_src_a, ack_tgt_a;
    logic         mem_en_a, mem_wr_en_a;
    logic [23:0]  mem_addr_a;
    logic [255:0] mem_wd_a, mem_rd_a;
    logic [31:0]  mem_be_a, mem_rsb_a, mem_asb_a;
    logic [2:0]   credit_a;

    logic         req_vld_b, req_rdy_b;
    logic [31:0]  req_addr_b;
    logic [3:0]   req_src_b;
    logic         ack_vld_b, ack_rdy_b, ack_op_b;
    logic [255:0] ack_data_b;
    logic [31:0]  ack_sb_b;
    logic [3:0]   ack_src_b, ack_tgt_b;
    logic         mem_en_b, mem_wr_en_b;
    logic [23:0]  mem_addr_b;
    logic [255:0] mem_wd_b, mem_rd_b;
    logic [31:0]  mem_be_b, mem_rsb_b, mem_asb_b;
    logic [1:0]   credit_b;

    function automatic logic [255:0] word(input logic [23:0] wa);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = {8'(i) + 8'h10, wa};
        return w;
    endfunction

    function automatic logic [31:0] sbf(input logic [23:0] wa);
        return {8'hC3, ~wa};
    endfunction

    function automatic logic [23:0] wa_of(input logic [31:0] a);
        return 24'(a / 32);
    endfunction

    // Memory for A answers one cycle after the address; B reads combinationally.
    always @(posedge clk) begin
        mem_rd_a  <= word(mem_addr_a);
        mem_asb_a <= sbf(mem_addr_a);
    end
    assign mem_rd_b  = word(mem_addr_b);
    assign mem_asb_b = sbf(mem_addr_b);

    toy_bus_mem_slave_pipe u_a (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld_a), .req_rdy(req_rdy_a),
        .req_addr(req_addr_a), .req_strb(req_strb_a),
        .req_data(req_data_a), .req_opcode(req_op_a),
        .req_src_id(req_src_a), .req_tgt_id(req_tgt_a),
        .req_sideband(req_sb_a),
        .ack_vld(ack_vld_a), .ack_rdy(ack_rdy_a),
        .ack_opcode(ack_op_a), .ack_data(ack_data_a),
        .ack_sideband(ack_sb_a), .ack_src_id(ack_src_a),
        .ack_tgt_id(ack_tgt_a),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a),
        .mem_wr_en(mem_wr_en_a), .mem_wr_data(mem_wd_a),
        .mem_wr_byte_en(mem_be_a), .mem_req_sideband(mem_rsb_a),
        .mem_rd_data(mem_rd_a), .mem_ack_sideband(mem_asb_a),
        .credit_cnt(credit_a)
    );

    toy_bus_mem_slave_pipe #(.RD_LAT(1), .ACK_DEPTH(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld_b), .req_rdy(req_rdy_b),
        .req_addr(req_addr_b), .req_strb(32'h0),
        .req_data(256'h0), .req_opcode(1'b0),
        .req_src_id(req_src_b), .req_tgt_id(4'h0),
        .req_sideband(32'h0),
        .ack_vld(ack_vld_b), .ack_rdy(ack_rdy_b),
        .ack_opcode(ack_op_b), .ack_data(ack_data_b),
        .ack_sideband(ack_sb_b), .ack_src_id(ack_src_b),
        .ack_tgt_id(ack_tgt_b),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b),
        .mem_wr_en(mem_wr_en_b), .mem_wr_data(mem_wd_b),
        .mem_wr_byte_en(mem_be_b), .mem_req_sideband(mem_rsb_b),
        .mem_rd_data(mem_rd_b), .mem_ack_sideband(mem_asb_b),
        .credit_cnt(credit_b)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] data;
        logic [31:0]  sb;
        logic [3:0]   id;
        logic         op;
        int           rdy;
    } exp_t;

    exp_t q[$];

    // Reference for A: every ack-producing accept becomes an expected ack
    // visible RD_LAT cycles later, delivered in order, one credit each.
    always @(negedge clk) begin : mon_a
        bit   ev;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            chk("rst_ack_vld", ack_vld_a, 0);
            chk("rst_ack_data", ack_data_a, 0);
            chk("rst_credit", credit_a, 0);
            chk("rst_req_rdy", req_rdy_a, 1);
        end else begin
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("ack_vld", ack_vld_a, ev);
            chk("credit", credit_a, q.size());
            chk("req_rdy", req_rdy_a, q.size() < 4);
            if (ack_vld_a && ev) begin
                chk("ack_data", ack_data_a, q[0].data);
                chk("ack_sb", ack_sb_a, q[0].sb);
                chk("ack_tgt", ack_tgt_a, q[0].id);
                chk("ack_op", ack_op_a, q[0].op);
                chk("ack_src", ack_src_a, 0);
            end
            if (ack_vld_a && ack_rdy_a && q.size() > 0) q.pop_front();
            if (req_vld_a && req_rdy_a && (!req_op_a || WR)) begin
                e.data = req_op_a ? 256'h0 : word(wa_of(req_addr_a));
                e.sb   = sbf(wa_of(req_addr_a));
                e.id   = req_src_a;
                e.op   = req_op_a;
                e.rdy  = cyc + 2;
                q.push_back(e);
            end
        end
    end

    typedef struct {
        logic        vld;
        logic        op;
        logic [31:0] addr;
        logic [31:0] strb;
        logic [31:0] sb;
        logic        exp_en;
        logic        exp_wr;
        logic [23:0] exp_ma;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t         tbl [6];
        exp_t         qb[$];
        exp_t         eb;
        int           nacc, npop, nack, maxc;
        bit           hold;
        logic [255:0] prev;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h11, 1'b0, 1'b0, 24'h000002};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h22, 1'b1, 1'b0, 24'h000002};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 32'h33, 1'b1, 1'b1, 24'h000091};
        tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFE0, 32'h0000_0000, 32'h44, 1'b1, 1'b0, 24'hFFFFFF};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_001F, 32'h0000_0000, 32'h55, 1'b1, 1'b0, 24'h000000};
        tbl[5] = '{1'b1, 1'b1, 32'h2000_0020, 32'h0000_00F0, 32'h66, 1'b1, 1'b1, 24'h000001};

        req_vld_a = 0; req_op_a = 0; req_addr_a = 0; req_strb_a = 0;
        req_sb_a = 0; req_data_a = 0; req_src_a = 0; req_tgt_a = 4'hF;
        ack_rdy_a = 1;
        req_vld_b = 0; req_addr_b = 0; req_src_b = 0; ack_rdy_b = 1;

        repeat (2) @(negedge clk);
        chk("reset_tgt", ack_tgt_a, 0);
        tick();
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            tick();
            req_vld_a  = tbl[i].vld;
            req_op_a   = tbl[i].op;
            req_addr_a = tbl[i].addr;
            req_strb_a = tbl[i].strb;
            req_sb_a   = tbl[i].sb;
            req_data_a = {8{tbl[i].addr}};
            req_src_a  = 4'(i);
            @(negedge clk);
            chk("tbl_mem_en", mem_en_a, tbl[i].exp_en);
            chk("tbl_mem_wr_en", mem_wr_en_a, tbl[i].exp_wr);
            chk("tbl_mem_addr", mem_addr_a, tbl[i].exp_ma);
            chk("tbl_mem_be", mem_be_a, tbl[i].strb);
            chk("tbl_mem_sb", mem_rsb_a, tbl[i].sb);
            chk("tbl_mem_wd", mem_wd_a, {8{tbl[i].addr}});
        end
        tick();
        req_vld_a = 0; req_op_a = 0;
        repeat (6) @(negedge clk);

        tick();
        req_vld_a = 1; req_addr_a = 32'h0000_0040; req_src_a = 4'd3;
        @(negedge clk);
        chk("single_mem_en", mem_en_a, 1);
        chk("single_mem_addr", mem_addr_a, 24'd2);
        tick();
        req_vld_a = 0;
        @(negedge clk);
        chk("single_early", ack_vld_a, 0);
        @(negedge clk);
        chk("single_vld", ack_vld_a, 1);
        chk("single_tgt", ack_tgt_a, 4'd3);
        chk("single_op", ack_op_a, 0);
        chk("single_data", ack_data_a, word(24'd2));
        repeat (3) @(negedge clk);

        ack_rdy_a = 0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            req_vld_a = 1; req_addr_a = 32'(i * 32 + 32'h400); req_src_a = 4'(i);
            @(negedge clk);
            if (req_vld_a && req_rdy_a) nacc++;
        end
        tick();
        req_vld_a = 0;
        @(negedge clk);
        chk("burst_accepts", nacc, 4);
        chk("burst_credit", credit_a, 4);
        chk("burst_rdy_low", req_rdy_a, 0);
        tick();
        ack_rdy_a = 1;
        @(negedge clk);
        chk("burst_no_bypass", req_rdy_a, 0);
        npop = (ack_vld_a && ack_rdy_a) ? 1 : 0;
        @(negedge clk);
        chk("burst_rdy_back", req_rdy_a, 1);
        if (ack_vld_a && ack_rdy_a) npop++;
        repeat (6) begin
            @(negedge clk);
            if (ack_vld_a && ack_rdy_a) npop++;
        end
        chk("burst_pops", npop, 4);

        maxc = 0;
        hold = 0;
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            req_vld_a = 1; req_op_a = 0;
            req_addr_a = $urandom; req_src_a = 4'($urandom);
            ack_rdy_a = (i % 2 == 0);
            @(negedge clk);
            if (hold) chk("stall_stable", ack_data_a, prev);
            hold = ack_vld_a && !ack_rdy_a;
            prev = ack_data_a;
            if (int'(credit_a) > maxc) maxc = int'(credit_a);
        end
        tick();
        req_vld_a = 0; ack_rdy_a = 1;
        repeat (8) @(negedge clk);
        chk("stream_max_credit", maxc <= 4, 1);
        chk("stream_drained", q.size(), 0);

        tick();
        req_vld_a = 1; req_op_a = 1; req_strb_a = 32'hFFFF_FFFF;
        req_addr_a = 32'h0000_0080; req_src_a = 4'd5;
        @(negedge clk);
        chk("wr_mem_wr_en", mem_wr_en_a, 1);
        chk("wr_mem_be", mem_be_a, 32'hFFFF_FFFF);
        tick();
        req_vld_a = 0; req_op_a = 0;
        @(negedge clk);
        nack = ack_vld_a ? 1 : 0;
        @(negedge clk);
        if (WR) begin
            chk("wr_ack_vld", ack_vld_a, 1);
            chk("wr_ack_op", ack_op_a, 1);
            chk("wr_ack_data", ack_data_a, 0);
        end
        if (ack_vld_a) nack++;
        repeat (3) begin
            @(negedge clk);
            if (ack_vld_a) nack++;
        end
        chk("wr_ack_count", nack, WR ? 1 : 0);

        ack_rdy_a = 0;
        tick();
        req_vld_a = 1; req_addr_a = 32'h0000_0100; req_src_a = 4'd1;
        tick();
        req_addr_a = 32'h0000_0120; req_src_a = 4'd2;
        tick();
        req_vld_a = 0;
        #2 rst_n = 0;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        chk("rstmid_vld", ack_vld_a, 0);
        chk("rstmid_credit", credit_a, 0);
        chk("rstmid_rdy", req_rdy_a, 1);
        ack_rdy_a = 1;
        nack = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_vld_a) nack++;
        end
        chk("rstmid_no_stale", nack, 0);

        for (int i = 0; i < 300; i++) begin
            tick();
            req_vld_a  = ($urandom_range(0, 3) != 0);
            req_op_a   = ($urandom_range(0, 3) == 0);
            req_addr_a = $urandom;
            req_strb_a = $urandom;
            req_sb_a   = $urandom;
            req_data_a = {8{$urandom}};
            req_src_a  = 4'($urandom);
            ack_rdy_a  = ($urandom_range(0, 2) != 0);
        end
        tick();
        req_vld_a = 0; ack_rdy_a = 1;
        repeat (10) @(negedge clk);
        chk("rand_drained", q.size(), 0);

        for (int k = 0; k < 20; k++) begin
            tick();
            req_vld_b  = 1;
            req_addr_b = $urandom;
            req_src_b  = 4'($urandom);
            @(negedge clk);
            chk("b_rdy", req_rdy_b, 1);
            if (k == 0) chk("b_first_empty", ack_vld_b, 0);
            if (k > 0) begin
                chk("b_ack_vld", ack_vld_b, 1);
                if (qb.size() > 0) begin
                    chk("b_ack_data", ack_data_b, qb[0].data);
                    chk("b_ack_tgt", ack_tgt_b, qb[0].id);
                    void'(qb.pop_front());
                end
            end
            if (req_vld_b && req_rdy_b) begin
                eb.data = word(wa_of(req_addr_b));
                eb.sb   = 32'h0;
                eb.id   = req_src_b;
                eb.op   = 1'b0;
                eb.rdy  = 0;
                qb.push_back(eb);
            end
        end
        tick();
        req_vld_b = 0;
        @(negedge clk);
        chk("b_last_vld", ack_vld_b, 1);
        if (qb.size() > 0) chk("b_last_data", ack_data_b, qb[0].data);
        @(negedge clk);
        chk("b_idle", ack_vld_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
